// File: rtl/rf_alu_ctrl.sv
// Instruction sequencer and signed saturating ALU that sits behind a register file.
// Each instruction runs IDLE -> READ -> EXEC -> WRITE, so one instruction completes every 4 cycles.
module rf_alu_ctrl #(
  parameter int BW    = 8,
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid_i,
  output logic                 instr_ready_o,
  input  logic [2:0]           opcode_i,
  input  logic [AW-1:0]        src1_i,
  input  logic [AW-1:0]        src2_i,
  input  logic [AW-1:0]        dst_i,
  output logic [AW-1:0]        rf_read_addr_1_o,
  output logic [AW-1:0]        rf_read_addr_2_o,
  input  logic signed [BW-1:0] rf_data_1_i,
  input  logic signed [BW-1:0] rf_data_2_i,
  output logic [AW-1:0]        rf_write_addr_o,
  output logic signed [BW-1:0] rf_data_o,
  output logic                 rf_write_en_n_o,
  output logic                 rf_chip_en_o,
  output logic                 done_o,
  output logic signed [BW-1:0] result_o,
  output logic                 ovf_o
);

  localparam int SHW = (BW > 1) ? $clog2(BW) : 1;
  localparam logic signed [BW-1:0] SAT_MAX = {1'b0, {(BW-1){1'b1}}};
  localparam logic signed [BW-1:0] SAT_MIN = {1'b1, {(BW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_e;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
    OP_XOR = 3'b100, OP_MUL = 3'b101, OP_SRA = 3'b110, OP_MOV = 3'b111
  } op_e;

  state_e                state;
  op_e                   op_q;
  logic [AW-1:0]         dst_q;
  logic signed [BW-1:0]  a_q;
  logic signed [BW-1:0]  b_q;

  logic signed [BW:0]    add_w;
  logic signed [BW:0]    sub_w;
  logic signed [2*BW-1:0] mul_w;
  logic signed [BW-1:0]  alu_res;
  logic                  alu_ovf;

  // Overflow is detected when the bits above the result's sign bit disagree with it.
  always_comb begin
    add_w   = {a_q[BW-1], a_q} + {b_q[BW-1], b_q};
    sub_w   = {a_q[BW-1], a_q} - {b_q[BW-1], b_q};
    mul_w   = (2*BW)'(a_q) * (2*BW)'(b_q);
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op_q)
      OP_ADD: begin
        if (add_w[BW] != add_w[BW-1]) begin
          alu_ovf = 1'b1;
          alu_res = add_w[BW] ? SAT_MIN : SAT_MAX;
        end else begin
          alu_res = add_w[BW-1:0];
        end
      end
      OP_SUB: begin
        if (sub_w[BW] != sub_w[BW-1]) begin
          alu_ovf = 1'b1;
          alu_res = sub_w[BW] ? SAT_MIN : SAT_MAX;
        end else begin
          alu_res = sub_w[BW-1:0];
        end
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_MUL: begin
        if ((mul_w[2*BW-1:BW-1] != '0) && (mul_w[2*BW-1:BW-1] != '1)) begin
          alu_ovf = 1'b1;
          alu_res = mul_w[2*BW-1] ? SAT_MIN : SAT_MAX;
        end else begin
          alu_res = mul_w[BW-1:0];
        end
      end
      OP_SRA: alu_res = a_q >>> b_q[SHW-1:0];
      OP_MOV: alu_res = a_q;
      default: alu_res = '0;
    endcase
  end

  // Handshake-side outputs are registered on the transition into each state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      op_q             <= OP_ADD;
      dst_q            <= '0;
      a_q              <= '0;
      b_q              <= '0;
      rf_read_addr_1_o <= '0;
      rf_read_addr_2_o <= '0;
      instr_ready_o    <= 1'b1;
      rf_chip_en_o     <= 1'b0;
      rf_write_en_n_o  <= 1'b1;
      done_o           <= 1'b0;
      result_o         <= '0;
      ovf_o            <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (instr_valid_i && instr_ready_o) begin
            op_q             <= op_e'(opcode_i);
            dst_q            <= dst_i;
            rf_read_addr_1_o <= src1_i;
            rf_read_addr_2_o <= src2_i;
            instr_ready_o    <= 1'b0;
            rf_chip_en_o     <= 1'b1;
            state            <= S_READ;
          end
        end
        S_READ: begin
          a_q          <= rf_data_1_i;
          b_q          <= rf_data_2_i;
          rf_chip_en_o <= 1'b0;
          state        <= S_EXEC;
        end
        S_EXEC: begin
          result_o        <= alu_res;
          ovf_o           <= alu_ovf;
          rf_write_en_n_o <= 1'b0;
          rf_chip_en_o    <= 1'b1;
          done_o          <= 1'b1;
          state           <= S_WRITE;
        end
        S_WRITE: begin
          rf_write_en_n_o <= 1'b1;
          rf_chip_en_o    <= 1'b0;
          done_o          <= 1'b0;
          instr_ready_o   <= 1'b1;
          state           <= S_IDLE;
        end
        default: begin
          instr_ready_o   <= 1'b1;
          rf_chip_en_o    <= 1'b0;
          rf_write_en_n_o <= 1'b1;
          done_o          <= 1'b0;
          state           <= S_IDLE;
        end
      endcase
    end
  end

  assign rf_write_addr_o = dst_q;
  assign rf_data_o       = result_o;

endmodule

// File: tb/tb_rf_alu_ctrl.sv
// Directed bench for rf_alu_ctrl with a behavioural register file attached to its ports.
module tb_rf_alu_ctrl;

  localparam int BW    = 8;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic                 clk;
  logic                 rst_n;
  logic                 instr_valid;
  logic                 instr_ready;
  logic [2:0]           opcode;
  logic [AW-1:0]        src1, src2, dst;
  logic [AW-1:0]        rd_addr_1, rd_addr_2, wr_addr;
  logic signed [BW-1:0] rd_data_1, rd_data_2, wr_data;
  logic                 wr_en_n, chip_en, done, ovf;
  logic signed [BW-1:0] result;

  logic signed [BW-1:0] mem [DEPTH];
  int                   wr_cnt;
  int                   done_cnt;
  int                   checks;
  int                   errors;

  rf_alu_ctrl #(.BW(BW), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .instr_valid_i    (instr_valid),
    .instr_ready_o    (instr_ready),
    .opcode_i         (opcode),
    .src1_i           (src1),
    .src2_i           (src2),
    .dst_i            (dst),
    .rf_read_addr_1_o (rd_addr_1),
    .rf_read_addr_2_o (rd_addr_2),
    .rf_data_1_i      (rd_data_1),
    .rf_data_2_i      (rd_data_2),
    .rf_write_addr_o  (wr_addr),
    .rf_data_o        (wr_data),
    .rf_write_en_n_o  (wr_en_n),
    .rf_chip_en_o     (chip_en),
    .done_o           (done),
    .result_o         (result),
    .ovf_o            (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rd_data_1 = mem[rd_addr_1];
  assign rd_data_2 = mem[rd_addr_2];

  always @(posedge clk) begin
    if (chip_en && !wr_en_n) begin
      mem[wr_addr] <= wr_data;
      wr_cnt       <= wr_cnt + 1;
    end
  end

  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Handshake, wait for done, let the write commit, then check result, flag and RF contents.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [AW-1:0] d,
                        input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                        input int exp_res, input int exp_ovf);
    int lat;
    @(negedge clk);
    instr_valid = 1'b1; opcode = op; dst = d; src1 = s1; src2 = s2;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 10);
    check({tag, "_lat"}, lat, 3);
    check({tag, "_wen"}, int'(wr_en_n), 0);
    @(posedge clk);
    #1;
    check({tag, "_res"}, int'(result), exp_res);
    check({tag, "_ovf"}, int'(ovf), exp_ovf);
    check({tag, "_rf"}, int'(mem[d]), exp_res);
    check({tag, "_done_off"}, int'(done), 0);
  endtask

  initial begin
    int rdy_low;
    checks = 0; errors = 0; wr_cnt = 0; done_cnt = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    instr_valid = 1'b0; opcode = '0; src1 = '0; src2 = '0; dst = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", int'(instr_ready), 1);
    check("rst_done", int'(done), 0);
    check("rst_wen_n", int'(wr_en_n), 1);
    check("rst_chip_en", int'(chip_en), 0);
    check("rst_result", int'(result), 0);
    rst_n = 1'b1;

    // idle with valid low: no RF activity
    repeat (3) @(negedge clk);
    check("idle_chip_en", int'(chip_en), 0);
    check("idle_wr_cnt", wr_cnt, 0);

    mem[1] = 8'sd5; mem[2] = 8'sd7;
    run_op("add", 3'b000, 8'd3, 8'd1, 8'd2, 12, 0);
    mem[1] = 8'sd100; mem[2] = 8'sd100;
    run_op("add_sat", 3'b000, 8'd3, 8'd1, 8'd2, 127, 1);
    mem[1] = -8'sd100;
    run_op("sub_sat", 3'b001, 8'd3, 8'd1, 8'd2, -128, 1);
    mem[1] = 8'sd20; mem[2] = 8'sd50;
    run_op("sub", 3'b001, 8'd5, 8'd1, 8'd2, -30, 0);
    mem[1] = -8'sd3; mem[2] = 8'sd20;
    run_op("mul", 3'b101, 8'd3, 8'd1, 8'd2, -60, 0);
    mem[1] = 8'sd16; mem[2] = 8'sd16;
    run_op("mul_sat", 3'b101, 8'd3, 8'd1, 8'd2, 127, 1);
    mem[1] = -8'sd16;
    run_op("mul_nsat", 3'b101, 8'd3, 8'd1, 8'd2, -128, 1);
    mem[1] = -8'sd64; mem[2] = 8'sd3;
    run_op("sra", 3'b110, 8'd3, 8'd1, 8'd2, -8, 0);
    mem[2] = 8'sd9;
    run_op("sra_wrap", 3'b110, 8'd3, 8'd1, 8'd2, -32, 0);
    mem[1] = 8'sh0F; mem[2] = -8'sd1;
    run_op("xor", 3'b100, 8'd3, 8'd1, 8'd2, -16, 0);
    mem[1] = 8'sh3C; mem[2] = 8'sh0F;
    run_op("and", 3'b010, 8'd6, 8'd1, 8'd2, 12, 0);
    run_op("or", 3'b011, 8'd6, 8'd1, 8'd2, 63, 0);
    mem[7] = 8'sd9;
    run_op("self_add", 3'b000, 8'd7, 8'd7, 8'd7, 18, 0);

    // back-to-back dependency with valid held high
    mem[1] = 8'sd10; mem[2] = 8'sd11; mem[3] = '0; mem[4] = '0;
    @(negedge clk);
    done_cnt = 0;
    instr_valid = 1'b1; opcode = 3'b000; dst = 8'd3; src1 = 8'd1; src2 = 8'd2;
    @(posedge clk);
    #1 opcode = 3'b111; dst = 8'd4; src1 = 8'd3; src2 = 8'd0;
    rdy_low = 0;
    @(negedge clk);
    while (!instr_ready && rdy_low < 10) begin
      rdy_low++;
      @(negedge clk);
    end
    check("b2b_ready_low", rdy_low, 3);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("b2b_r3", int'(mem[3]), 21);
    check("b2b_r4", int'(mem[4]), 21);
    check("b2b_done_cnt", done_cnt, 2);

    // reset during EXEC discards the instruction
    mem[1] = 8'sd5; mem[2] = 8'sd7; mem[3] = 8'sh55;
    @(negedge clk);
    instr_valid = 1'b1; opcode = 3'b000; dst = 8'd3; src1 = 8'd1; src2 = 8'd2;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    wr_cnt = 0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", int'(instr_ready), 1);
    check("mid_rst_wen_n", int'(wr_en_n), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_wr_cnt", wr_cnt, 0);
    check("mid_rst_r3", int'(mem[3]), 8'h55);
    check("post_rst_ready", int'(instr_ready), 1);
    check("post_rst_done", int'(done), 0);
    check("post_rst_chip_en", int'(chip_en), 0);
    check("post_rst_addr1", int'(rd_addr_1), 0);
    check("post_rst_addr2", int'(rd_addr_2), 0);
    check("post_rst_waddr", int'(wr_addr), 0);
    check("post_rst_wdata", int'(wr_data), 0);
    check("post_rst_result", int'(result), 0);
    check("post_rst_ovf", int'(ovf), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
